// File: rtl/key_schedule_seq.sv
// AES-128/192/256 key expansion, one 32-bit schedule word per clock, with the full
// schedule held in a register array and any round key served on a registered read port.
module key_schedule_seq #(
  parameter int unsigned MAX_NK = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           key_len,
  input  logic [32*MAX_NK-1:0] key,
  output logic                 busy,
  output logic                 keys_valid,
  output logic                 cfg_err,
  input  logic [3:0]           rk_idx,
  output logic [127:0]         rk_out
);
  localparam int unsigned KW    = 32 * MAX_NK;
  localparam int unsigned DEPTH = 4 * (MAX_NK + 7);
  localparam int unsigned AW    = $clog2(DEPTH);

  // Forward S-box, entry 255 first, so SBOX[~x] is S(x).
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[~x[31:24]], SBOX[~x[23:16]], SBOX[~x[15:8]], SBOX[~x[7:0]]};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [31:0]     r_w [DEPTH];
  logic [3:0]      r_nk;
  logic [3:0]      r_nr;
  logic [AW-1:0]   r_i;
  logic [AW-1:0]   r_last_i;
  logic [2:0]      r_mod;
  logic [7:0]      r_rcon;

  logic [3:0]      w_nk_req;
  logic [3:0]      w_nr_req;
  logic            w_len_ok;
  logic            w_can_start;
  logic            w_accept;
  logic            w_reject;
  logic            w_last;
  logic [31:0]     w_prev;
  logic [31:0]     w_back;
  logic [31:0]     w_sub_in;
  logic [31:0]     w_sub;
  logic [31:0]     w_t;
  logic [31:0]     w_new;
  logic [AW-1:0]   w_base;
  logic [127:0]    w_rk;

  // Key-length decode and start acceptance.
  always_comb begin
    w_nk_req = '0;
    w_nr_req = '0;
    case (key_len)
      2'b00:   begin w_nk_req = 4'd4; w_nr_req = 4'd10; end
      2'b01:   begin w_nk_req = 4'd6; w_nr_req = 4'd12; end
      2'b10:   begin w_nk_req = 4'd8; w_nr_req = 4'd14; end
      default: ;
    endcase
    w_len_ok    = (key_len != 2'b11) && (32'(w_nk_req) <= MAX_NK);
    w_can_start = start && (r_state != S_EXPAND);
    w_accept    = w_can_start && w_len_ok;
    w_reject    = w_can_start && !w_len_ok;
  end

  // One expansion step: r_mod tracks i mod Nk, so a single S-box pass suffices.
  always_comb begin
    w_prev   = r_w[r_i - AW'(1)];
    w_back   = r_w[r_i - AW'(r_nk)];
    w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    w_sub    = sub_word(w_sub_in);
    if (r_mod == 3'd0)
      w_t = w_sub ^ {r_rcon, 24'h0};
    else if ((r_nk == 4'd8) && (r_mod == 3'd4))
      w_t = w_sub;
    else
      w_t = w_prev;
    w_new  = w_back ^ w_t;
    w_last = (r_i == r_last_i);
  end

  // Round-key read mux: column c is schedule word 4*rk_idx+c.
  always_comb begin
    w_base = AW'({rk_idx, 2'b00});
    w_rk   = '0;
    if (rk_idx <= r_nr) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          w_rk[127-32*r-8*c -: 8] = r_w[w_base + AW'(c)][31-8*r -: 8];
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_accept) w_next_state = S_EXPAND;
      S_EXPAND:       if (w_last)   w_next_state = S_DONE;
      default:        w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      busy       <= (w_next_state == S_EXPAND);
      keys_valid <= (w_next_state == S_DONE);
      cfg_err    <= w_reject;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rk_out <= '0;
    else        rk_out <= w_rk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < int'(DEPTH); j++) r_w[j] <= '0;
      r_nk     <= 4'd4;
      r_nr     <= '0;
      r_i      <= '0;
      r_last_i <= '0;
      r_mod    <= '0;
      r_rcon   <= 8'h01;
    end else if (w_accept) begin
      for (int j = 0; j < int'(MAX_NK); j++) begin
        if (j < int'(w_nk_req)) r_w[j] <= key[KW-1-32*j -: 32];
      end
      r_nk     <= w_nk_req;
      r_nr     <= w_nr_req;
      r_i      <= AW'(w_nk_req);
      r_last_i <= AW'({w_nr_req, 2'b11});
      r_mod    <= '0;
      r_rcon   <= 8'h01;
    end else if (r_state == S_EXPAND) begin
      r_w[r_i] <= w_new;
      r_i      <= r_i + AW'(1);
      r_mod    <= (4'(r_mod) == (r_nk - 4'd1)) ? 3'd0 : r_mod + 3'd1;
      if (r_mod == 3'd0) r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    end
  end

endmodule

// File: tb/tb_key_schedule_seq.sv
// Bench for key_schedule_seq: FIPS-197 vectors plus random keys against a GF(2^8)-based
// reference expansion; a second instance with MAX_NK=4 covers oversize-key rejection.
module tb_key_schedule_seq;
  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic [3:0]   rk_idx;
  logic         busy, keys_valid, cfg_err;
  logic [127:0] rk_out;

  logic         s4_start;
  logic [1:0]   s4_key_len;
  logic [127:0] s4_key;
  logic [3:0]   s4_rk_idx;
  logic         s4_busy, s4_keys_valid, s4_cfg_err;
  logic [127:0] s4_rk_out;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tsbox [256];
  logic [31:0] mw [60];
  int          m_nr;

  always #5 clk = ~clk;

  key_schedule_seq #(.MAX_NK(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .keys_valid(keys_valid), .cfg_err(cfg_err),
    .rk_idx(rk_idx), .rk_out(rk_out)
  );

  key_schedule_seq #(.MAX_NK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .key_len(s4_key_len), .key(s4_key),
    .busy(s4_busy), .keys_valid(s4_keys_valid), .cfg_err(s4_cfg_err),
    .rk_idx(s4_rk_idx), .rk_out(s4_rk_out)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? (8'(x << 1) ^ 8'h1b) : 8'(x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    return 8'((b << k) | (b >> (8 - k)));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      tsbox[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {tsbox[x[31:24]], tsbox[x[23:16]], tsbox[x[15:8]], tsbox[x[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] k, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    int          tw;
    m_nr = nk + 6;
    tw   = 4 * (m_nr + 1);
    rc   = 8'h01;
    for (int j = 0; j < nk; j++) mw[j] = k[255-32*j -: 32];
    for (int i = nk; i < tw; i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int idx);
    logic [127:0] v;
    v = '0;
    if (idx <= m_nr)
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          v[127-32*r-8*c -: 8] = mw[4*idx+c][31-8*r -: 8];
    return v;
  endfunction

  function automatic logic [31:0] col_word(input logic [127:0] v, input int c);
    return {v[127-8*c -: 8], v[95-8*c -: 8], v[63-8*c -: 8], v[31-8*c -: 8]};
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] len, input logic [255:0] k);
    @(negedge clk);
    start = 1'b1; key_len = len; key = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles (bounded); optionally pulses start at busy cycle inject_at.
  task automatic count_busy(input int inject_at, output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == inject_at) begin
        start = 1'b1; key_len = 2'b10; key = rand_key();
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic read_rk(input int idx, output logic [127:0] v);
    @(negedge clk);
    rk_idx = 4'(idx);
    @(negedge clk);
    v = rk_out;
  endtask

  task automatic full_compare(input string tag);
    logic [127:0] v;
    for (int idx = 0; idx <= m_nr + 1; idx++) begin
      read_rk(idx, v);
      chk($sformatf("%s_rk%0d", tag, idx), v, model_rk(idx));
    end
  endtask

  localparam logic [255:0] K1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK1_0  = 128'h2b28ab097eaef7cf15d2154f16a6883c;
  localparam logic [127:0] RK1_10 = 128'hd0c9e1b614ee3f63f9250c0ca889c8a6;

  initial begin
    int           n;
    int           nk;
    logic [127:0] v;
    logic [255:0] rk;

    rst_n = 1'b0; start = 1'b0; key_len = 2'b00; key = '0; rk_idx = '0;
    s4_start = 1'b0; s4_key_len = 2'b00; s4_key = '0; s4_rk_idx = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_keys_valid", 128'(keys_valid), 128'(0));
    chk("reset_cfg_err", 128'(cfg_err), 128'(0));
    chk("reset_rk_out", rk_out, 128'h0);
    chk("reset4_busy", 128'(s4_busy), 128'(0));
    chk("reset4_rk_out", s4_rk_out, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // AES-128 FIPS vector
    model_expand(K1, 4);
    do_start(2'b00, K1);
    chk("t1_busy_on_accept", 128'(busy), 128'(1));
    chk("t1_kv_on_accept", 128'(keys_valid), 128'(0));
    count_busy(0, n);
    chk("t1_busy_cycles", 128'(n), 128'(40));
    chk("t1_keys_valid", 128'(keys_valid), 128'(1));
    read_rk(0, v);  chk("t1_rk0", v, RK1_0);
    read_rk(10, v); chk("t1_rk10", v, RK1_10);
    full_compare("t1");

    // Reserved key_len rejected in DONE; schedule is retained
    do_start(2'b11, rand_key());
    chk("rej_cfg_err", 128'(cfg_err), 128'(1));
    chk("rej_busy", 128'(busy), 128'(0));
    chk("rej_kv_kept", 128'(keys_valid), 128'(1));
    @(negedge clk);
    chk("rej_cfg_err_pulse", 128'(cfg_err), 128'(0));
    read_rk(10, v); chk("rej_rk10_kept", v, RK1_10);

    // Oversize key on the MAX_NK=4 instance, then a normal AES-128 run there
    @(negedge clk);
    s4_start = 1'b1; s4_key_len = 2'b10; s4_key = rand_key()[127:0];
    @(negedge clk);
    s4_start = 1'b0;
    chk("nk4_rej_cfg_err", 128'(s4_cfg_err), 128'(1));
    chk("nk4_rej_busy", 128'(s4_busy), 128'(0));
    @(negedge clk);
    chk("nk4_rej_pulse", 128'(s4_cfg_err), 128'(0));
    s4_start = 1'b1; s4_key_len = 2'b00; s4_key = K1[255 -: 128];
    @(negedge clk);
    s4_start = 1'b0;
    n = 0;
    while (s4_busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
    chk("nk4_busy_cycles", 128'(n), 128'(40));
    s4_rk_idx = 4'd10;
    @(negedge clk);
    chk("nk4_rk10", s4_rk_out, RK1_10);

    // AES-192 FIPS vector
    model_expand(K2, 6);
    do_start(2'b01, K2);
    count_busy(0, n);
    chk("t2_busy_cycles", 128'(n), 128'(46));
    read_rk(12, v); chk("t2_w51", 128'(col_word(v, 3)), 128'(32'h01002202));
    read_rk(13, v); chk("t2_rk13_zero", v, 128'h0);
    full_compare("t2");

    // AES-256 FIPS vector, started back-to-back from DONE
    model_expand(K3, 8);
    do_start(2'b10, K3);
    chk("t6_kv_drop", 128'(keys_valid), 128'(0));
    chk("t6_busy", 128'(busy), 128'(1));
    count_busy(0, n);
    chk("t3_busy_cycles", 128'(n), 128'(52));
    chk("t3_keys_valid", 128'(keys_valid), 128'(1));
    read_rk(14, v); chk("t3_w59", 128'(col_word(v, 3)), 128'(32'h706c631e));
    full_compare("t3");

    // Start during EXPAND is ignored
    model_expand(K1, 4);
    do_start(2'b00, K1);
    count_busy(10, n);
    chk("ign_busy_cycles", 128'(n), 128'(40));
    read_rk(10, v); chk("ign_rk10", v, RK1_10);

    // Reset mid-expansion
    do_start(2'b00, K1);
    repeat (19) @(negedge clk);
    chk("mid_busy_before_rst", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_kv", 128'(keys_valid), 128'(0));
    chk("mid_rst_cfg_err", 128'(cfg_err), 128'(0));
    chk("mid_rst_rk_out", rk_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    read_rk(0, v); chk("mid_rst_storage_clear", v, 128'h0);
    do_start(2'b00, K1);
    count_busy(0, n);
    chk("restart_busy_cycles", 128'(n), 128'(40));
    read_rk(0, v);  chk("restart_rk0", v, RK1_0);
    read_rk(10, v); chk("restart_rk10", v, RK1_10);

    // Random keys of every length against the reference model
    for (int it = 0; it < 6; it++) begin
      nk = 4 + 2 * (it % 3);
      rk = rand_key();
      model_expand(rk, nk);
      do_start(2'(it % 3), rk);
      count_busy(0, n);
      chk($sformatf("rand%0d_busy_cycles", it), 128'(n), 128'(4 * (nk + 7) - nk));
      full_compare($sformatf("rand%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_schedule_seq.md
Name: key_schedule_seq

Overview:
- Sequential, parametrised successor to the combinational one-round AES-128 key expansion.
- Expands an AES-128, AES-192 or AES-256 cipher key into the full round-key schedule, one 32-bit word per clock.
- Stores every word in an internal register array and serves any round key through a registered read port.
- Sits between key load and the round pipeline, which reads round keys by index instead of chaining rounds through the key path.

Parameters:
- MAX_NK, 8, largest supported key length in 32-bit words (4, 6 or 8). Sets the key port width (32*MAX_NK) and the storage depth (4*(MAX_NK+7) words).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin an expansion.
- key_len  in  2  2'b00=128, 2'b01=192, 2'b10=256, 2'b11 reserved. Sampled only when start is accepted.
- key  in  32*MAX_NK  cipher key in FIPS-197 byte order.
  - Byte n is at [8n +: 8], with bits numbered 0 = MSB.
  - Word w[j] = key[32j +: 32]; unused upper words are ignored.
- busy  out  1  high while expansion is in progress.
- keys_valid  out  1  high while a complete schedule is held.
- cfg_err  out  1  one-cycle pulse when a start is rejected.
- rk_idx  in  4  round-key index to read, 0..Nr.
- rk_out  out  128  round key rk_idx in row-major state layout.
  - Byte (row r, col c) is at [32r+8c +: 8] and equals byte r of w[4*rk_idx+c].
  - This is the same layout as the existing AES-128 round-key format.

Behaviour:
- Reset: all outputs are 0 (busy, keys_valid, cfg_err, rk_out); the FSM goes to IDLE; storage is cleared to 0; the rcon register is set to 8'h01.
- Derived constants:
  - Nk = 4/6/8 and Nr = 10/12/14.
  - Total words TW = 4*(Nr+1), i.e. 44/52/60.
- FSM states: IDLE, EXPAND, DONE.
- Start acceptance:
  - start is accepted in IDLE or DONE; it is ignored while in EXPAND (busy=1).
  - Rejection: key_len=2'b11, or Nk>MAX_NK. On rejection, cfg_err pulses for one cycle and state and stored keys are unchanged.
- Accept edge:
  - Latch Nk and Nr.
  - Write w[0..Nk-1] from key.
  - Set i=Nk and rcon=8'h01.
  - keys_valid goes to 0, busy goes to 1, state goes to EXPAND.
- EXPAND: each cycle writes exactly one word w[i], using t = w[i-1]:
  - If i mod Nk == 0: t = SubWord(RotWord(t)) ^ {rcon, 24'h0}, then rcon = xtime(rcon).
    - RotWord: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
    - xtime: shift left by 1; if bit 7 was set, XOR with 8'h1b. This gives the sequence 01,02,...,80,1b,36.
  - Else if Nk==8 and i mod 8 == 4: t = SubWord(t).
  - Else t is used unchanged.
  - w[i] = w[i-Nk] ^ t; then i = i+1.
  - Only one 4-byte S-box lookup per cycle.
  - i mod Nk is tracked with a wrap counter, not a divider.
- Completion: on the edge that writes w[TW-1], state goes to DONE, busy goes to 0 and keys_valid goes to 1.
  - Latency from the accept edge to keys_valid=1 is TW-Nk cycles: 40/46/52.
- DONE: holds the schedule indefinitely; a new accepted start restarts the expansion and overwrites storage.
- Read port:
  - rk_out is registered, giving 1-cycle latency from rk_idx.
  - It is valid for any rk_idx <= Nr whose 4 words are written; reads during EXPAND return the words written so far.
  - rk_idx > Nr returns 128'h0.
- Reset during EXPAND aborts immediately: state goes to IDLE, keys_valid=0, storage is cleared.
- start asserted in the same cycle as the final EXPAND write is ignored; the design enters DONE normally.

Test Plan:
1. AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
   - busy stays high for exactly 40 cycles, then keys_valid=1.
   - rk_idx=0 -> rk_out=2b28ab097eaef7cf15d2154f16a6883c.
   - rk_idx=10 -> rk_out=d0c9e1b614ee3f63f9250c0ca889c8a6.
2. AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
   - 46 busy cycles; w[51]=01002202, i.e. rk_idx=12 column 3.
   - rk_idx=13 -> 0.
3. AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
   - 52 busy cycles; w[59]=706c631e.
   - This exercises the SubWord step at i mod 8 == 4.
4. Rejection and ignore:
   - key_len=2'b11 -> cfg_err pulse, busy stays 0.
   - With MAX_NK=4 and key_len=2'b10 -> cfg_err pulse.
   - start during EXPAND -> ignored; the final result matches test 1.
5. Reset mid-expansion: deassert rst_n at cycle 20 of the AES-128 run -> all outputs 0 immediately; a restart then gives the test 1 values.
6. Back-to-back runs: in DONE, start with a new AES-256 key -> keys_valid drops on the accept edge and rises after 52 cycles with the test 3 values.
